// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions for the RAW10 unpacking path.
// Contents: data type codes, group geometry, byte/pixel typedefs.
package csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_LS    = 6'h02;
    localparam logic [5:0] DT_LE    = 6'h03;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    localparam int NUM_LANES = 4;   // pixels per RAW10 group
    localparam int GRP_BYTES = 5;   // bytes per RAW10 group
    localparam int BUF_BYTES = 8;   // carry-over + one payload word

    typedef logic [7:0] byte_t;
    typedef logic [9:0] pixel10_t;

endpackage

// File: rtl/csi2_raw10_group.sv
// Combinational RAW10 mapper: 5 payload bytes -> 4 x 10-bit pixels.
// Ports:
//   grp_bytes  in   5x8   bytes of one group, [0] earliest on the wire
//   pixel      out  4x10  pixels, [0] leftmost
// Byte 4 carries the two LSBs of every pixel, pixel k in bits [2k+1:2k].
module csi2_raw10_group
    import csi2_pkg::*;
(
    input  logic [GRP_BYTES-1:0][7:0] grp_bytes,
    output logic [NUM_LANES-1:0][9:0] pixel
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_pix
        assign pixel[k] = {grp_bytes[k], grp_bytes[4][2*k+1 -: 2]};
    end

endmodule

// File: rtl/csi2_raw10_unpacker.sv
// RAW10 long-packet unpacker sitting behind the CSI-2 lane receiver.
// Collects 4-byte payload words into an 8-byte buffer and emits one
// 4-pixel group whenever 5 bytes are available; marks line start/end and
// flags packets whose length leaves 1..4 bytes over.
// Ports:
//   clock, reset_n        clock, async active-low reset
//   virtual_channel[1:0]  VC of current packet
//   word_count[15:0]      payload length in bytes (latched at packet start)
//   image_data[3:0][7:0]  payload bytes, [0] earliest
//   image_data_type[7:0]  data type byte (low 6 bits compared)
//   image_data_enable     image_data valid
//   pixel[3:0][9:0]       unpacked group, [0] leftmost
//   pixel_enable          group valid
//   line_start/line_end   first / last group of a packet
//   format_error          packet ended with leftover bytes
module csi2_raw10_unpacker
    import csi2_pkg::*;
#(
    parameter logic [5:0] DATA_TYPE = DT_RAW10,
    parameter logic       VC_FILTER = 1'b0,
    parameter logic [1:0] VC_SELECT = 2'd0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                virtual_channel,
    input  logic [15:0]               word_count,
    input  logic [3:0][7:0]           image_data,
    input  logic [7:0]                image_data_type,
    input  logic                      image_data_enable,
    output logic [NUM_LANES-1:0][9:0] pixel,
    output logic                      pixel_enable,
    output logic                      line_start,
    output logic                      line_end,
    output logic                      format_error
);

    logic [BUF_BYTES-1:0][7:0] buf_q, buf_nxt, app;
    logic [2:0]                bcnt_q;      // 0..4 bytes carried between accepts
    logic [3:0]                app_cnt, rem_cnt;
    logic [15:0]               cnt_q, len_q, len_eff, remaining, cnt_nxt;
    logic [2:0]                n_bytes;
    logic                      first_q;     // packet open, no group emitted yet
    logic                      accept, take, pkt_start, emit, pkt_end;
    logic [NUM_LANES-1:0][9:0] grp_pix;
    logic                      unused_dt_hi;

    assign unused_dt_hi = ^image_data_type[7:6];

    assign accept    = image_data_enable && (image_data_type[5:0] == DATA_TYPE) &&
                       (!VC_FILTER || (virtual_channel == VC_SELECT));
    assign pkt_start = (cnt_q == 16'd0);
    assign len_eff   = pkt_start ? word_count : len_q;
    // A zero-length packet carries no payload; never let it open a packet.
    assign take      = accept && (len_eff != 16'd0);

    // Bytes past LEN in the final word are padding and never enter the buffer.
    assign remaining = len_eff - cnt_q;
    assign n_bytes   = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
    assign app_cnt   = {1'b0, bcnt_q} + {1'b0, n_bytes};
    assign emit      = take && (app_cnt >= 4'd5);
    assign rem_cnt   = emit ? (app_cnt - 4'd5) : app_cnt;
    assign cnt_nxt   = cnt_q + {13'd0, n_bytes};
    assign pkt_end   = take && (cnt_nxt == len_eff);

    always_comb begin
        app = buf_q;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < n_bytes) app[3'(bcnt_q + 3'(j))] = image_data[j];
        end
    end

    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) buf_nxt[i] = emit ? 8'h00 : app[i];
        for (int i = 0; i < BUF_BYTES - GRP_BYTES; i++) begin
            if (emit) buf_nxt[i] = app[i + GRP_BYTES];
        end
    end

    csi2_raw10_group u_group (
        .grp_bytes (app[GRP_BYTES-1:0]),
        .pixel     (grp_pix)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q        <= '0;
            bcnt_q       <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            first_q      <= 1'b0;
            pixel        <= '0;
            pixel_enable <= 1'b0;
            line_start   <= 1'b0;
            line_end     <= 1'b0;
            format_error <= 1'b0;
        end else begin
            pixel_enable <= emit;
            line_start   <= emit && (pkt_start || first_q);
            line_end     <= pkt_end;
            format_error <= pkt_end && (rem_cnt != 4'd0);
            if (emit) pixel <= grp_pix;
            if (take) begin
                if (pkt_start) len_q <= word_count;
                if (pkt_end) begin
                    // Leftover bytes of a short packet are dropped here.
                    cnt_q   <= '0;
                    bcnt_q  <= '0;
                    buf_q   <= '0;
                    first_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_nxt;
                    bcnt_q  <= rem_cnt[2:0];
                    buf_q   <= buf_nxt;
                    first_q <= (pkt_start || first_q) && !emit;
                end
            end
        end
    end

endmodule
